// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: instruction memory, redirect and decode handshake.
// master = fetch unit side, slave = memory/decode/branch side.
interface fetch_unit_if;
  logic [31:0] imemAddr;
  logic [31:0] imemInstr;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        decValid;
  logic        decReady;
  logic [31:0] decInstr;
  logic [31:0] decPc;
  logic        fetchFault;

  modport master (
    output imemAddr,
    input  imemInstr,
    input  redirectValid,
    input  redirectPc,
    output decValid,
    input  decReady,
    output decInstr,
    output decPc,
    output fetchFault
  );

  modport slave (
    input  imemAddr,
    output imemInstr,
    output redirectValid,
    output redirectPc,
    input  decValid,
    output decReady,
    input  decInstr,
    input  decPc,
    input  fetchFault
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end: PC, 1-cycle imem read tracking, 2-entry decode queue.
// Ports: clk, rst (sync active-high), bus (fetch_unit_if.master).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic [31:0] fetch_pc;
  logic        req_valid;
  logic [31:0] req_pc;
  entry_t      q [2];
  logic [1:0]  count;
  logic        fault;

  logic        pop;
  logic        wr;
  logic        issue;
  logic        aligned;
  logic [2:0]  occ;
  entry_t      wr_ent;

  assign pop     = (count != 2'd0) && bus.decReady;
  assign wr      = req_valid;
  assign wr_ent  = {bus.imemInstr, req_pc};
  assign aligned = (bus.redirectPc[1:0] == 2'b00);

  // Slots that will be occupied after this edge if nothing new issues:
  // a read in flight always lands, so it must be reserved now.
  assign occ   = {1'b0, count} + {2'b00, req_valid} - {2'b00, pop};
  assign issue = !fault && (occ < 3'd2);

  assign bus.imemAddr = rst ? RESET_PC :
                        bus.redirectValid ?
                        {bus.redirectPc[31:2], 2'b00} :
                        fetch_pc;

  assign bus.decValid   = (count != 2'd0);
  assign bus.decInstr   = bus.decValid ? q[0].instr : 32'h0;
  assign bus.decPc      = bus.decValid ? q[0].pc : 32'h0;
  assign bus.fetchFault = fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      req_valid <= 1'b0;
      req_pc    <= 32'h0;
      count     <= 2'd0;
      fault     <= 1'b0;
      q[0]      <= '0;
      q[1]      <= '0;
    end else if (bus.redirectValid) begin
      // Flush queue and drop any read in flight.
      count <= 2'd0;
      if (aligned) begin
        req_valid <= 1'b1;
        req_pc    <= bus.redirectPc;
        fetch_pc  <= bus.redirectPc + 32'd4;
        fault     <= 1'b0;
      end else begin
        req_valid <= 1'b0;
        fetch_pc  <= {bus.redirectPc[31:2], 2'b00};
        fault     <= 1'b1;
      end
    end else begin
      if (issue) begin
        req_valid <= 1'b1;
        req_pc    <= fetch_pc;
        fetch_pc  <= fetch_pc + 32'd4;
      end else begin
        req_valid <= 1'b0;
      end

      // Head is always q[0]; pop shifts q[1] down.
      unique case (1'b1)
        (pop && wr): begin
          if (count == 2'd1) begin
            q[0] <= wr_ent;
          end else begin
            q[0] <= q[1];
            q[1] <= wr_ent;
          end
        end
        (pop && !wr): begin
          q[0]  <= q[1];
          count <= count - 2'd1;
        end
        (!pop && wr): begin
          q[count[0]] <= wr_ent;
          count       <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
